// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl: button-driven minutes:seconds BCD countdown with set/run/pause/alarm sequencing.
// Define EGG_ALARM_TIMEOUT_EN to let the alarm return to IDLE by itself after ALARM_TICKS ticks.

module egg_timer_ctrl_chk #(
   parameter int MAX_MIN = 59
) (
   input logic       clk,
   input logic       reset,
   input logic [3:0] min_tens,
   input logic [3:0] min_ones,
   input logic [3:0] sec_tens,
   input logic [3:0] sec_ones,
   input logic       running,
   input logic       alarm,
   input logic       done
);
   a_sec_range: assert property (@(posedge clk) disable iff (reset)
      (sec_tens <= 4'd5) && (sec_ones <= 4'd9));
   a_min_range: assert property (@(posedge clk) disable iff (reset)
      (min_ones <= 4'd9) && ((int'(min_tens) * 10 + int'(min_ones)) <= MAX_MIN));
   a_done_in_alarm: assert property (@(posedge clk) disable iff (reset) done |-> alarm);
   a_done_single: assert property (@(posedge clk) disable iff (reset) done |=> !done);
   a_run_xor_alarm: assert property (@(posedge clk) disable iff (reset) !(running && alarm));
endmodule

module egg_timer_ctrl #(
   parameter int MAX_MIN     = 59,
   parameter int ALARM_TICKS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       btn_start,
   input  logic       btn_min,
   input  logic       btn_sec,
   input  logic       btn_clear,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       alarm,
   output logic       done
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ALARM = 2'd3
   } state_t;

   localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

   function automatic logic [7:0] min_inc(input logic [7:0] m);
      logic [7:0] r;
      if (m == {MAX_TENS, MAX_ONES}) begin
         r = 8'h00;
      end else if (m[3:0] == 4'd9) begin
         r = {m[7:4] + 4'd1, 4'd0};
      end else begin
         r = {m[7:4], m[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [7:0] sec_inc(input logic [7:0] s);
      logic [7:0] r;
      if (s == 8'h59) begin
         r = 8'h00;
      end else if (s[3:0] == 4'd9) begin
         r = {s[7:4] + 4'd1, 4'd0};
      end else begin
         r = {s[7:4], s[3:0] + 4'd1};
      end
      return r;
   endfunction

   // Time word is {min_tens, min_ones, sec_tens, sec_ones}; 00:00 decrements to itself.
   function automatic logic [15:0] time_dec(input logic [15:0] t);
      logic [15:0] r;
      r = t;
      if (t[3:0] != 4'd0) begin
         r[3:0] = t[3:0] - 4'd1;
      end else if (t[7:4] != 4'd0) begin
         r[7:4] = t[7:4] - 4'd1;
         r[3:0] = 4'd9;
      end else if (t[15:8] != 8'h00) begin
         r[7:0] = 8'h59;
         if (t[11:8] != 4'd0) begin
            r[11:8] = t[11:8] - 4'd1;
         end else begin
            r[15:12] = t[15:12] - 4'd1;
            r[11:8]  = 4'd9;
         end
      end else begin
         r = t;
      end
      return r;
   endfunction

   state_t      state_r;
   state_t      state_nx_s;
   logic [15:0] time_r;
   logic [15:0] time_nx_s;
   logic [15:0] dec_s;
   logic [3:0]  btn_q_r;
   logic [3:0]  press_s;
   logic        clr_s;
   logic        start_s;
   logic        min_s;
   logic        sec_s;
   logic        running_r;
   logic        alarm_r;
   logic        done_r;
   logic        alarm_timeout_s;

   // Bit order {clear, start, min, sec} doubles as the priority order.
   assign press_s = {btn_clear, btn_start, btn_min, btn_sec} & ~btn_q_r;
   assign clr_s   = press_s[3];
   assign start_s = !press_s[3] && press_s[2];
   assign min_s   = (press_s[3:2] == 2'b00) && press_s[1];
   assign sec_s   = (press_s[3:1] == 3'b000) && press_s[0];
   assign dec_s   = time_dec(time_r);

`ifdef EGG_ALARM_TIMEOUT_EN
   localparam int CNT_W = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALARM_TICKS - 1);

   logic [CNT_W-1:0] alarm_cnt_r;

   // Counts ticks spent in ALARM; held at zero elsewhere so it starts fresh on every entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         alarm_cnt_r <= '0;
      end else if (state_r != ST_ALARM) begin
         alarm_cnt_r <= '0;
      end else if (tick_1hz) begin
         alarm_cnt_r <= alarm_cnt_r + CNT_W'(1);
      end else begin
         alarm_cnt_r <= alarm_cnt_r;
      end
   end

   assign alarm_timeout_s = tick_1hz && (alarm_cnt_r == CNT_LAST);
`else
   logic [31:0] alarm_ticks_unused_s;
   assign alarm_ticks_unused_s = 32'(ALARM_TICKS);
   assign alarm_timeout_s      = 1'b0;
`endif

   // Next-state and next-time decode.
   always_comb begin
      state_nx_s = state_r;
      time_nx_s  = time_r;
      case (state_r)
         ST_IDLE: begin
            if (clr_s) begin
               time_nx_s = 16'h0000;
            end else if (start_s) begin
               if (time_r != 16'h0000) begin
                  state_nx_s = ST_RUN;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end else if (min_s) begin
               time_nx_s[15:8] = min_inc(time_r[15:8]);
            end else if (sec_s) begin
               time_nx_s[7:0] = sec_inc(time_r[7:0]);
            end else begin
               time_nx_s = time_r;
            end
         end
         ST_RUN: begin
            if (clr_s) begin
               state_nx_s = ST_IDLE;
               time_nx_s  = 16'h0000;
            end else begin
               if (tick_1hz) begin
                  time_nx_s = dec_s;
               end else begin
                  time_nx_s = time_r;
               end
               // Reaching zero outranks a coincident pause request.
               if (tick_1hz && (dec_s == 16'h0000)) begin
                  state_nx_s = ST_ALARM;
               end else if (start_s) begin
                  state_nx_s = ST_PAUSE;
               end else begin
                  state_nx_s = ST_RUN;
               end
            end
         end
         ST_PAUSE: begin
            if (clr_s) begin
               state_nx_s = ST_IDLE;
               time_nx_s  = 16'h0000;
            end else if (start_s) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_PAUSE;
            end
         end
         ST_ALARM: begin
            time_nx_s = 16'h0000;
            if (clr_s || start_s || alarm_timeout_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_ALARM;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            time_nx_s  = 16'h0000;
         end
      endcase
   end

   // State, count, button history and registered status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         time_r    <= 16'h0000;
         btn_q_r   <= 4'b1111;
         running_r <= 1'b0;
         alarm_r   <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         time_r    <= time_nx_s;
         btn_q_r   <= {btn_clear, btn_start, btn_min, btn_sec};
         running_r <= (state_nx_s == ST_RUN);
         alarm_r   <= (state_nx_s == ST_ALARM);
         done_r    <= (state_nx_s == ST_ALARM) && (state_r != ST_ALARM);
      end
   end

   assign min_tens = time_r[15:12];
   assign min_ones = time_r[11:8];
   assign sec_tens = time_r[7:4];
   assign sec_ones = time_r[3:0];
   assign running  = running_r;
   assign alarm    = alarm_r;
   assign done     = done_r;

   egg_timer_ctrl_chk #(.MAX_MIN(MAX_MIN)) u_chk (
      .clk      (clk),
      .reset    (reset),
      .min_tens (time_r[15:12]),
      .min_ones (time_r[11:8]),
      .sec_tens (time_r[7:4]),
      .sec_ones (time_r[3:0]),
      .running  (running_r),
      .alarm    (alarm_r),
      .done     (done_r)
   );

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Scoreboard bench for egg_timer_ctrl: directed stimulus queues expected outputs, a negedge monitor compares.
// Builds with or without EGG_ALARM_TIMEOUT_EN (ALARM_TICKS is 3 here).
module tb_egg_timer_ctrl;
   localparam int MAX_MIN     = 59;
   localparam int ALARM_TICKS = 3;
   localparam logic [3:0] B_NONE  = 4'b0000;
   localparam logic [3:0] B_SEC   = 4'b0001;
   localparam logic [3:0] B_MIN   = 4'b0010;
   localparam logic [3:0] B_START = 4'b0100;
   localparam logic [3:0] B_CLR   = 4'b1000;

   logic       clk;
   logic       reset;
   logic       tick_1hz;
   logic       btn_start;
   logic       btn_min;
   logic       btn_sec;
   logic       btn_clear;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running;
   logic       alarm;
   logic       done;

   typedef struct packed {
      logic [15:0] digits;
      logic        run;
      logic        alm;
      logic        dn;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    tests_run = 0;
   int    failed    = 0;
   exp_t  mon_exp;
   exp_t  mon_act;
   string mon_name;

   egg_timer_ctrl #(.MAX_MIN(MAX_MIN), .ALARM_TICKS(ALARM_TICKS)) dut (
      .clk       (clk),
      .reset     (reset),
      .tick_1hz  (tick_1hz),
      .btn_start (btn_start),
      .btn_min   (btn_min),
      .btn_sec   (btn_sec),
      .btn_clear (btn_clear),
      .min_tens  (min_tens),
      .min_ones  (min_ones),
      .sec_tens  (sec_tens),
      .sec_ones  (sec_ones),
      .running   (running),
      .alarm     (alarm),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: one queued expectation is compared per falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_name = name_q.pop_front();
         mon_act = {min_tens, min_ones, sec_tens, sec_ones, running, alarm, done};
         tests_run++;
         if (mon_act !== mon_exp) begin
            failed++;
            $display("FAIL %s: got %h%h:%h%h run=%b alarm=%b done=%b, expected %h:%h run=%b alarm=%b done=%b",
                     mon_name, min_tens, min_ones, sec_tens, sec_ones, running, alarm, done,
                     mon_exp.digits[15:8], mon_exp.digits[7:0], mon_exp.run, mon_exp.alm, mon_exp.dn);
         end
      end
   end

   task automatic cyc(input logic [3:0] b, input logic t);
      {btn_clear, btn_start, btn_min, btn_sec} = b;
      tick_1hz = t;
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] b);
      cyc(b, 1'b0);
      cyc(B_NONE, 1'b0);
   endtask

   task automatic chk(input string n, input logic [15:0] d, input logic r, input logic a, input logic dn);
      exp_t e;
      e = {d, r, a, dn};
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   function automatic logic [15:0] secs_bcd(input int s);
      return {8'h00, 4'(s / 10), 4'(s % 10)};
   endfunction

   initial begin
      reset = 1'b1;
      tick_1hz = 1'b0;
      {btn_clear, btn_start, btn_min, btn_sec} = B_NONE;

      // Reset hold-off with btn_min held high
      cyc(B_MIN, 1'b0);
      cyc(B_MIN, 1'b0);
      chk("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(B_MIN, 1'b0);
         chk("held_through_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      end
      cyc(B_NONE, 1'b0);
      cyc(B_MIN, 1'b0);
      chk("first_min_press", 16'h0100, 1'b0, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);

      // Setting wrap and priority
      for (int i = 0; i < 60; i++) begin
         press(B_SEC);
         if (i == 58) chk("sec_59", 16'h0159, 1'b0, 1'b0, 1'b0);
      end
      chk("sec_wrap", 16'h0100, 1'b0, 1'b0, 1'b0);
      cyc(B_MIN | B_SEC, 1'b0);
      chk("min_over_sec", 16'h0200, 1'b0, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);
      press(B_CLR);
      chk("idle_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         press(B_MIN);
         if (i == 9) chk("min_carry", 16'h1000, 1'b0, 1'b0, 1'b0);
         if (i == 58) chk("min_max", 16'h5900, 1'b0, 1'b0, 1'b0);
      end
      chk("min_wrap", 16'h0000, 1'b0, 1'b0, 1'b0);
      cyc(B_START, 1'b0);
      chk("start_at_zero", 16'h0000, 1'b0, 1'b0, 1'b0);
      cyc(B_NONE, 1'b1);
      chk("idle_tick_ignored", 16'h0000, 1'b0, 1'b0, 1'b0);

      // Countdown borrow to alarm
      press(B_MIN);
      chk("set_0100", 16'h0100, 1'b0, 1'b0, 1'b0);
      cyc(B_START, 1'b0);
      chk("run_start", 16'h0100, 1'b1, 1'b0, 1'b0);
      cyc(B_NONE, 1'b1);
      chk("borrow_minute", 16'h0059, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 59; i++) begin
         cyc(B_NONE, 1'b1);
         chk("countdown", secs_bcd(59 - i), 1'b1, 1'b0, 1'b0);
      end
      cyc(B_NONE, 1'b1);
      chk("alarm_entry", 16'h0000, 1'b0, 1'b1, 1'b1);
      cyc(B_MIN, 1'b0);
      chk("alarm_min_ignored", 16'h0000, 1'b0, 1'b1, 1'b0);
      cyc(B_NONE, 1'b0);
      chk("alarm_hold", 16'h0000, 1'b0, 1'b1, 1'b0);

      // Alarm exit
`ifdef EGG_ALARM_TIMEOUT_EN
      cyc(B_NONE, 1'b1);
      chk("alarm_tick1", 16'h0000, 1'b0, 1'b1, 1'b0);
      cyc(B_NONE, 1'b1);
      chk("alarm_tick2", 16'h0000, 1'b0, 1'b1, 1'b0);
      cyc(B_NONE, 1'b1);
      chk("alarm_timeout", 16'h0000, 1'b0, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);
`else
      for (int i = 0; i < 20; i++) begin
         cyc(B_NONE, 1'b1);
         chk("alarm_persist", 16'h0000, 1'b0, 1'b1, 1'b0);
      end
      cyc(B_CLR, 1'b0);
      chk("alarm_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);
`endif

      // Pause and coincident events
      for (int i = 0; i < 30; i++) press(B_SEC);
      chk("set_0030", 16'h0030, 1'b0, 1'b0, 1'b0);
      cyc(B_START, 1'b0);
      chk("run_0030", 16'h0030, 1'b1, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);
      cyc(B_START, 1'b1);
      chk("tick_start_pause", 16'h0029, 1'b0, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(B_NONE, 1'b1);
         chk("pause_tick_ignored", 16'h0029, 1'b0, 1'b0, 1'b0);
      end
      cyc(B_MIN, 1'b0);
      chk("pause_min_ignored", 16'h0029, 1'b0, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);
      cyc(B_START, 1'b0);
      chk("resume", 16'h0029, 1'b1, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);
      cyc(B_SEC, 1'b0);
      chk("run_sec_ignored", 16'h0029, 1'b1, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);
      for (int i = 1; i < 29; i++) begin
         cyc(B_NONE, 1'b1);
         chk("countdown2", secs_bcd(29 - i), 1'b1, 1'b0, 1'b0);
      end
      cyc(B_START, 1'b1);
      chk("tick_start_alarm_wins", 16'h0000, 1'b0, 1'b1, 1'b1);
      cyc(B_NONE, 1'b0);
      chk("done_one_cycle", 16'h0000, 1'b0, 1'b1, 1'b0);
      cyc(B_START, 1'b0);
      chk("alarm_start_exit", 16'h0000, 1'b0, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);

      // Clear priority, minute-tens borrow, mid-run reset
      for (int i = 0; i < 2; i++) press(B_MIN);
      for (int i = 0; i < 15; i++) press(B_SEC);
      chk("set_0215", 16'h0215, 1'b0, 1'b0, 1'b0);
      cyc(B_START, 1'b0);
      chk("run_0215", 16'h0215, 1'b1, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);
      cyc(B_CLR | B_START, 1'b1);
      chk("clear_beats_start_tick", 16'h0000, 1'b0, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);
      for (int i = 0; i < 10; i++) press(B_MIN);
      chk("set_1000", 16'h1000, 1'b0, 1'b0, 1'b0);
      cyc(B_START, 1'b0);
      chk("run_1000", 16'h1000, 1'b1, 1'b0, 1'b0);
      cyc(B_NONE, 1'b1);
      chk("borrow_min_tens", 16'h0959, 1'b1, 1'b0, 1'b0);
      press(B_CLR);
      chk("run_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) press(B_SEC);
      chk("set_0010", 16'h0010, 1'b0, 1'b0, 1'b0);
      cyc(B_START, 1'b0);
      chk("run_0010", 16'h0010, 1'b1, 1'b0, 1'b0);
      cyc(B_NONE, 1'b1);
      chk("borrow_sec_tens", 16'h0009, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      cyc(B_START, 1'b0);
      chk("mid_run_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      cyc(B_START, 1'b0);
      chk("after_reset_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
      cyc(B_NONE, 1'b0);
      press(B_SEC);
      chk("post_reset_edit", 16'h0001, 1'b0, 1'b0, 1'b0);

      cyc(B_NONE, 1'b0);
      @(negedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         failed++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end
endmodule
